// File: rtl/game_ctrl_pkg.sv
// Shared game-controller definitions: state encodings, default timing
// parameters and the saturating BCD score increment.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int TICK_DIV_DEF   = 32;
  localparam int DB_CYCLES_DEF  = 1024;
  localparam int HOLD_TICKS_DEF = 64;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, counter debouncer and a
// one-clk press pulse on each debounced rising edge.
module btn_debounce
  import game_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample matching the current level restarts the run count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/READY/PLAY/OVER flow, game tick divider, BCD score
// and best-score tracking.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic               collide,
  input  logic               pipe_passed,
  input  logic signed [10:0] y_coord,
  output logic [1:0]         state,
  output logic               enable,
  output logic               jump,
  output logic               game_tick,
  output logic [7:0]         score,
  output logic [7:0]         best
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic start_level_unused, start_press;
  logic jump_level, jump_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_raw(btn_start),
    .level(start_level_unused), .press(start_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_jump (
    .clk(clk), .rst(rst), .btn_raw(btn_jump),
    .level(jump_level), .press(jump_press)
  );

  game_state_e   state_q, state_d;
  logic          enable_q, enable_d;
  logic          game_tick_q, game_tick_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    best_q, best_d;
  logic          game_end;

  always_comb begin
    tick_cnt_d  = (tick_cnt_q == TW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TW'(1);
    game_tick_d = (tick_cnt_q == TW'(TICK_DIV - 1));
    state_d     = state_q;
    hold_d      = hold_q;
    score_d     = score_q;
    best_d      = best_q;
    // A run-ending tick also swallows a coincident pipe_passed.
    game_end = game_tick_q && (collide || (y_coord <= 11'sd0));

    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d = ST_READY;
          score_d = 8'h00;
        end
      end
      ST_READY: begin
        if (jump_press) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (game_end) begin
          state_d = ST_OVER;
          hold_d  = HW'(HOLD_TICKS);
          if (score_q > best_q) best_d = score_q;
        end else if (pipe_passed) begin
          score_d = bcd_inc_sat(score_q);
        end
      end
      ST_OVER: begin
        if (game_tick_q && (hold_q != '0)) hold_d = hold_q - HW'(1);
        if (start_press && (hold_q == '0)) begin
          state_d = ST_READY;
          score_d = 8'h00;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      game_tick_q <= 1'b0;
      tick_cnt_q  <= '0;
      hold_q      <= '0;
      score_q     <= 8'h00;
      best_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      game_tick_q <= game_tick_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_q      <= hold_d;
      score_q     <= score_d;
      best_q      <= best_d;
    end
  end

  assign state     = state_q;
  assign enable    = enable_q;
  assign jump      = jump_level & enable_q;
  assign game_tick = game_tick_q;
  assign score     = score_q;
  assign best      = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default timing parameters.
module tb_game_ctrl;

  localparam int TD = 32;
  localparam int DB = 1024;
  localparam int HT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               btn_start = 1'b0;
  logic               btn_jump = 1'b0;
  logic               collide = 1'b0;
  logic               pipe_passed = 1'b0;
  logic signed [10:0] y_coord = 11'sd100;
  logic [1:0]         state;
  logic               enable, jump, game_tick;
  logic [7:0]         score, best;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_jump(btn_jump),
    .collide(collide), .pipe_passed(pipe_passed), .y_coord(y_coord),
    .state(state), .enable(enable), .jump(jump), .game_tick(game_tick),
    .score(score), .best(best)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (game_tick !== 1'b1 && n < 2 * TD) begin
      step(1);
      n++;
    end
    chk("tick_wait", game_tick, 1);
  endtask

  task automatic count_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      wait_tick();
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step(DB + 3);
    btn_start = 1'b0;
    step(DB + 4);
  endtask

  task automatic press_jump();
    btn_jump = 1'b1;
    step(DB + 3);
    btn_jump = 1'b0;
    step(DB + 4);
  endtask

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_passed = 1'b1;
      step(1);
      pipe_passed = 1'b0;
    end
  endtask

  initial begin
    step(2);
    chk("rst_state", state, 0);
    chk("rst_enable", enable, 0);
    chk("rst_jump", jump, 0);
    chk("rst_tick", game_tick, 0);
    chk("rst_score", score, 8'h00);
    chk("rst_best", best, 8'h00);
    rst = 1'b1;
    step(3);

    wait_tick();
    step(TD - 1);
    chk("tick_gap", game_tick, 0);
    step(1);
    chk("tick_period", game_tick, 1);

    btn_start = 1'b1;
    step(DB - 1);
    btn_start = 1'b0;
    step(DB + 4);
    chk("glitch_idle", state, 0);

    btn_start = 1'b1;
    step(DB + 2);
    chk("start_early", state, 0);
    step(1);
    chk("start_ready", state, 1);
    chk("ready_score", score, 8'h00);
    step(500);
    chk("start_held", state, 1);
    btn_start = 1'b0;
    step(DB + 4);
    chk("start_release", state, 1);

    pipes(2);
    chk("ready_no_score", score, 8'h00);

    btn_jump = 1'b1;
    step(DB + 2);
    chk("jump_early", state, 1);
    step(1);
    chk("play_state", state, 2);
    chk("play_enable", enable, 1);
    chk("play_jump", jump, 1);
    btn_jump = 1'b0;
    step(DB + 4);
    chk("jump_release", jump, 0);
    chk("play_stays", state, 2);

    pipes(7);
    chk("score7", score, 8'h07);
    wait_tick();
    collide = 1'b1;
    pipe_passed = 1'b1;
    step(1);
    collide = 1'b0;
    pipe_passed = 1'b0;
    chk("coll_state", state, 3);
    chk("coll_score", score, 8'h07);
    chk("coll_best", best, 8'h07);
    chk("coll_enable", enable, 0);
    chk("over_jump", jump, 0);

    count_ticks(10);
    btn_start = 1'b1;
    step(DB + 3);
    chk("hold_ignore", state, 3);
    btn_start = 1'b0;
    step(DB + 4);
    chk("hold_no_queue", state, 3);
    press_start();
    chk("rearm_state", state, 1);
    chk("rearm_score", score, 8'h00);
    chk("rearm_best", best, 8'h07);

    press_jump();
    chk("run2_play", state, 2);
    pipes(12);
    chk("score12", score, 8'h12);
    pipes(95);
    chk("score_sat", score, 8'h99);
    y_coord = 11'sd0;
    wait_tick();
    chk("floor_pre", state, 2);
    step(1);
    chk("floor_over", state, 3);
    chk("floor_best", best, 8'h99);
    y_coord = 11'sd100;
    count_ticks(HT);
    step(2);
    press_start();
    chk("hold_done_state", state, 1);
    chk("hold_done_score", score, 8'h00);
    chk("hold_done_best", best, 8'h99);

    press_jump();
    chk("run3_play", state, 2);
    pipes(5);
    chk("score5", score, 8'h05);
    #2;
    rst = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_score", score, 8'h00);
    chk("async_best", best, 8'h00);
    chk("async_enable", enable, 0);
    step(3);
    rst = 1'b1;
    step(20);
    chk("post_rst_idle", state, 0);
    press_jump();
    chk("idle_jump_ignored", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 32, clk cycles per game tick; the bird update rate is clk/32.
REQ-002 Parameter DB_CYCLES, default 1024, consecutive equal synchronised samples required to change a debounced button level.
REQ-003 Parameter HOLD_TICKS, default 64, game ticks the OVER state ignores btn_start.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 btn_start  in  1  raw start button, asynchronous, active-high.
REQ-007 btn_jump  in  1  raw jump button, asynchronous, active-high.
REQ-008 collide  in  1  bird/pipe overlap flag, synchronous to clk.
REQ-009 pipe_passed  in  1  one-clk pulse when a pipe clears the bird column.
REQ-010 y_coord  in  11  signed bird height; 0 is the floor.
REQ-011 state  out  2  game state: 0 IDLE, 1 READY, 2 PLAY, 3 OVER.
REQ-012 enable  out  1  high while state is PLAY.
REQ-013 jump  out  1  debounced jump level, gated to PLAY.
REQ-014 game_tick  out  1  one-clk pulse every TICK_DIV clk cycles.
REQ-015 score  out  8  two-digit BCD score of the current run.
REQ-016 best  out  8  two-digit BCD best score since reset.

Function
REQ-017 Each button SHALL pass through a 2-flop synchroniser, then a counter-based debouncer; the debounced level SHALL toggle only after DB_CYCLES consecutive samples that differ from it.
REQ-018 A press event SHALL be a one-clk pulse on the debounced rising edge; a held button SHALL produce no further events.
REQ-019 The tick counter SHALL free-run modulo TICK_DIV in every state; game_tick SHALL assert in the cycle the counter wraps to 0.
REQ-020 IDLE -> READY on a start press event.
REQ-021 READY -> PLAY on a jump press event; score SHALL clear to 00 on READY entry.
REQ-022 PLAY -> OVER in the cycle after game_tick samples collide=1 or y_coord<=0; collide and the floor check are evaluated only on game_tick.
REQ-023 OVER SHALL load a hold counter with HOLD_TICKS on entry and decrement it on each game_tick; OVER -> READY on a start press event only when the hold counter is 0; start presses during the hold SHALL be discarded, not queued.
REQ-024 No other transitions exist; jump presses outside READY and PLAY SHALL be ignored.
REQ-025 In PLAY, each pipe_passed pulse SHALL increment score by 1 in BCD (09 -> 10), saturating at 99.
REQ-026 If pipe_passed and a game_tick with collide=1 coincide, the collision SHALL win and score SHALL NOT increment.
REQ-027 On the PLAY -> OVER transition, best SHALL load score if score > best, in the same cycle that state becomes 3.
REQ-028 enable and state SHALL be registered and change in the same cycle; jump SHALL be 0 outside PLAY.

Reset
REQ-029 While rst=0: state=0, enable=0, jump=0, game_tick=0, score=00, best=00; the tick, debounce and hold counters and all synchroniser flops SHALL clear to 0.
REQ-030 Reset mid-PLAY SHALL take effect immediately (asynchronous assertion); after release the block SHALL be in IDLE and SHALL require a fresh start press.

Structure
REQ-031 A shared package SHALL hold the state encodings (IDLE/READY/PLAY/OVER) and the default values of TICK_DIV, DB_CYCLES and HOLD_TICKS, for use by game_ctrl, bird and the renderer.
REQ-032 The debouncer SHALL be one sub-module, btn_debounce (synchroniser plus counter, outputs level and press pulse), instantiated twice.

Verification
REQ-033 Reset, start held for DB_CYCLES+3 clk -> state 0->1 exactly once, score=00; holding start longer -> no further transition.
REQ-034 Start glitch of DB_CYCLES-1 clk, then release -> state stays 0.
REQ-035 In PLAY, 12 pipe_passed pulses -> score=0x12; 95 further pulses -> score saturates at 0x99.
REQ-036 In PLAY with score=0x07, pipe_passed on the same clk as a game_tick with collide=1 -> state=3, score=0x07, best=0x07, enable=0.
REQ-037 y_coord driven to 0 in PLAY -> state=3 one clk after the next game_tick; start press at hold tick 10 -> ignored; start press after 64 ticks -> state=1, score=00, best unchanged.
REQ-038 rst asserted mid-PLAY with score=0x05 -> state=0, score=00 and best=00 immediately, without a clk edge.
